fixed_acc_dump: RTL and testbench

- Downstream consumer of the pipelined saturating fixed-point adder.
- Takes the adder's registered sum/overflow/valid stream and accumulates a frame of `frame_len` samples in a wider accumulator (same Qm.n scale).
- Emits one saturated WIDTH-bit result per frame, plus a per-frame count of upstream overflow flags.
- Has no backpressure, because the adder has none: the block accepts a sample on every cycle it is presented.

---
 rtl/fixed_acc_dump.sv | 190 +++++++++++++++++++
 tb/tb_fixed_acc_dump.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fixed_acc_dump.sv
// Frame accumulator behind the saturating fixed-point adder: sums frame_len samples, dumps one saturated result.
// Optional averaging shift before narrowing is enabled with `define FXP_ACC_AVG_EN.
module fixed_acc_dump #(
    parameter int WIDTH     = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_WIDTH = 24,
    parameter int LEN_WIDTH = 8,
    parameter int LOG2_LEN  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_ovf,
    input  logic [LEN_WIDTH-1:0] frame_len,
    input  logic                 flush,
    output logic [WIDTH-1:0]     acc_out,
    output logic                 out_sat,
    output logic [LEN_WIDTH-1:0] ovf_cnt,
    output logic                 out_valid
);

    // state | meaning
    // IDLE  | no frame open; next accepted sample starts a frame
    // ACCUM | frame open, waiting for cnt == len or flush
    typedef enum logic {IDLE, ACCUM} state_t;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]     OUT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]     OUT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [LEN_WIDTH-1:0] LEN_ONES = '1;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

    if (ACC_WIDTH <= WIDTH || FRAC_BITS > WIDTH || LOG2_LEN < 0 || LOG2_LEN >= ACC_WIDTH) begin : g_param_check
        $error("fixed_acc_dump: illegal parameter combination");
    end

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [ACC_WIDTH-1:0]   snap_q, snap_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   ovf_q, ovf_d;
    logic [LEN_WIDTH-1:0]   snap_ovf_q, snap_ovf_d;
    logic                   acc_sat_q, acc_sat_d;
    logic                   snap_sat_q, snap_sat_d;
    logic                   pend_q, pend_d;
    logic [WIDTH-1:0]       acc_out_q, acc_out_d;
    logic                   out_sat_q, out_sat_d;
    logic [LEN_WIDTH-1:0]   ovf_cnt_q, ovf_cnt_d;
    logic                   out_valid_q, out_valid_d;

    logic [ACC_WIDTH-1:0]   in_ext;
    logic [ACC_WIDTH:0]     sum_wide;
    logic                   sum_ovf;
    logic [ACC_WIDTH-1:0]   sum_sat;
    logic [LEN_WIDTH-1:0]   ovf_inc;
    logic [LEN_WIDTH-1:0]   len_eff;
    logic                   dump;
    logic [ACC_WIDTH-1:0]   pre_narrow;
    logic                   fits;
    logic [WIDTH-1:0]       narrow_val;

    assign in_ext   = {{(ACC_WIDTH-WIDTH){in_data[WIDTH-1]}}, in_data};
    assign sum_wide = {acc_q[ACC_WIDTH-1], acc_q} + {in_ext[ACC_WIDTH-1], in_ext};
    assign sum_ovf  = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
    assign sum_sat  = sum_ovf ? (sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_WIDTH-1:0];
    assign ovf_inc  = (ovf_q == LEN_ONES) ? ovf_q : ovf_q + LEN_WIDTH'(in_ovf);
    assign len_eff  = (frame_len == '0) ? LEN_ONE : frame_len;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        ovf_d      = ovf_q;
        acc_sat_d  = acc_sat_q;
        snap_d     = snap_q;
        snap_sat_d = snap_sat_q;
        snap_ovf_d = snap_ovf_q;
        pend_d     = 1'b0;
        dump       = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d     = in_ext;
                    cnt_d     = LEN_ONE;
                    len_d     = len_eff;
                    ovf_d     = LEN_WIDTH'(in_ovf);
                    acc_sat_d = 1'b0;
                    state_d   = ACCUM;
                    dump      = (len_eff == LEN_ONE) || flush;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d     = sum_sat;
                    acc_sat_d = acc_sat_q | sum_ovf;
                    cnt_d     = cnt_q + LEN_ONE;
                    ovf_d     = ovf_inc;
                    dump      = (cnt_d == len_q) || flush;
                end else begin
                    dump      = flush;
                end
            end
            default: state_d = IDLE;
        endcase
        // Snapshot the post-update frame so the next sample can open a new frame immediately.
        if (dump) begin
            snap_d     = acc_d;
            snap_sat_d = acc_sat_d;
            snap_ovf_d = ovf_d;
            pend_d     = 1'b1;
            acc_d      = '0;
            cnt_d      = '0;
            ovf_d      = '0;
            acc_sat_d  = 1'b0;
            state_d    = IDLE;
        end
    end

`ifdef FXP_ACC_AVG_EN
    localparam logic [ACC_WIDTH:0] RND =
        (ACC_WIDTH+1)'((LOG2_LEN > 0) ? (1 << ((LOG2_LEN > 0) ? LOG2_LEN - 1 : 0)) : 0);
    logic [ACC_WIDTH:0]   rnd_wide;
    logic [ACC_WIDTH-1:0] rnd_val;
    assign rnd_wide   = {snap_q[ACC_WIDTH-1], snap_q} + RND;
    assign rnd_val    = (rnd_wide[ACC_WIDTH] != rnd_wide[ACC_WIDTH-1]) ? ACC_MAX : rnd_wide[ACC_WIDTH-1:0];
    assign pre_narrow = ACC_WIDTH'($signed(rnd_val) >>> LOG2_LEN);
`else
    assign pre_narrow = snap_q;
`endif

    // Value fits WIDTH bits when every bit above the result sign bit matches it.
    assign fits       = (&pre_narrow[ACC_WIDTH-1:WIDTH-1]) | ~(|pre_narrow[ACC_WIDTH-1:WIDTH-1]);
    assign narrow_val = fits ? pre_narrow[WIDTH-1:0] : (pre_narrow[ACC_WIDTH-1] ? OUT_MIN : OUT_MAX);

    always_comb begin
        acc_out_d   = acc_out_q;
        out_sat_d   = out_sat_q;
        ovf_cnt_d   = ovf_cnt_q;
        out_valid_d = pend_q;
        if (pend_q) begin
            acc_out_d = narrow_val;
            out_sat_d = snap_sat_q | ~fits;
            ovf_cnt_d = snap_ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            snap_q      <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            ovf_q       <= '0;
            snap_ovf_q  <= '0;
            acc_sat_q   <= 1'b0;
            snap_sat_q  <= 1'b0;
            pend_q      <= 1'b0;
            acc_out_q   <= '0;
            out_sat_q   <= 1'b0;
            ovf_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            snap_q      <= snap_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            snap_ovf_q  <= snap_ovf_d;
            acc_sat_q   <= acc_sat_d;
            snap_sat_q  <= snap_sat_d;
            pend_q      <= pend_d;
            acc_out_q   <= acc_out_d;
            out_sat_q   <= out_sat_d;
            ovf_cnt_q   <= ovf_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign acc_out   = acc_out_q;
    assign out_sat   = out_sat_q;
    assign ovf_cnt   = ovf_cnt_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fixed_acc_dump.sv
// Directed bench for fixed_acc_dump: expected frame results are queued at the last sample and checked on out_valid.
module tb_fixed_acc_dump;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ovf;
    logic [7:0]  frame_len;
    logic        flush;
    logic [15:0] acc_out;
    logic        out_sat;
    logic [7:0]  ovf_cnt;
    logic        out_valid;

    always #5 clk = ~clk;

    fixed_acc_dump #(
        .WIDTH(16), .FRAC_BITS(8), .ACC_WIDTH(24), .LEN_WIDTH(8), .LOG2_LEN(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ovf(in_ovf),
        .frame_len(frame_len), .flush(flush), .acc_out(acc_out), .out_sat(out_sat),
        .ovf_cnt(ovf_cnt), .out_valid(out_valid)
    );

    typedef struct {
        logic [15:0] d;
        logic        s;
        logic [7:0]  o;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic o, input logic f, input logic [7:0] len);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_ovf    = o;
        flush     = f;
        frame_len = len;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 1'b0, frame_len);
    endtask

    // Called in the same timestep as the step() that presents the frame's last sample.
    task automatic expect_out(input logic [15:0] d, input logic s, input logic [7:0] o);
        exp_t x;
        x.d = d; x.s = s; x.o = o; x.due = cyc + 2;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("acc_out", {16'b0, acc_out}, {16'b0, e.d});
                chk("out_sat", {31'b0, out_sat}, {31'b0, e.s});
                chk("ovf_cnt", {24'b0, ovf_cnt}, {24'b0, e.o});
                chk("latency", cyc, e.due);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ovf = 1'b0; frame_len = 8'd4; flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_acc_out", {16'b0, acc_out}, 32'd0);
        chk("rst_out_sat", {31'b0, out_sat}, 32'd0);
        chk("rst_ovf_cnt", {24'b0, ovf_cnt}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        rst_n = 1'b1;

        // basic 4-sample frame
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0100, 1'b0, 1'b0, 8'd4);
        expect_out(16'h0400, 1'b0, 8'd0);
        idle(3);

        // positive then negative narrowing saturation, back-to-back frames
        step(1'b1, 16'h7FFF, 1'b0, 1'b0, 8'd4);
        step(1'b1, 16'h7FFF, 1'b1, 1'b0, 8'd4);
        step(1'b1, 16'h7FFF, 1'b1, 1'b0, 8'd4);
        step(1'b1, 16'h7FFF, 1'b0, 1'b0, 8'd4);
        expect_out(16'h7FFF, 1'b1, 8'd2);
        for (int i = 0; i < 4; i++) step(1'b1, 16'h8000, 1'b0, 1'b0, 8'd4);
        expect_out(16'h8000, 1'b1, 8'd0);
        idle(3);

        // frame_len=2, continuous samples 1..6
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 16'(i), 1'b0, 1'b0, 8'd2);
            if (i % 2 == 0) expect_out(16'(2 * i - 1), 1'b0, 8'd0);
        end
        idle(3);

        // flush with a sample, then single-sample frames (len 1 and len 0)
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0010, 1'b0, 1'b0, 8'd8);
        step(1'b1, 16'h0010, 1'b0, 1'b1, 8'd8);
        expect_out(16'h0040, 1'b0, 8'd0);
        step(1'b1, 16'h0005, 1'b1, 1'b0, 8'd1);
        expect_out(16'h0005, 1'b0, 8'd1);
        step(1'b1, 16'h0009, 1'b0, 1'b0, 8'd0);
        expect_out(16'h0009, 1'b0, 8'd0);
        idle(2);

        // frame_len change mid-frame and gaps in in_valid
        step(1'b1, 16'h0001, 1'b0, 1'b0, 8'd3);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 8'd3);
        step(1'b1, 16'h0002, 1'b0, 1'b0, 8'd1);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 8'd1);
        step(1'b1, 16'h0003, 1'b0, 1'b0, 8'd1);
        expect_out(16'h0006, 1'b0, 8'd0);
        idle(2);

        // flush in IDLE without a sample is ignored; flush in ACCUM dumps the partial frame
        step(1'b0, 16'h0000, 1'b0, 1'b1, 8'd4);
        step(1'b1, 16'h0002, 1'b0, 1'b0, 8'd8);
        step(1'b1, 16'h0003, 1'b1, 1'b0, 8'd8);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 8'd8);
        expect_out(16'h0005, 1'b0, 8'd1);
        step(1'b1, 16'h0011, 1'b0, 1'b1, 8'd4);
        expect_out(16'h0011, 1'b0, 8'd0);
        idle(2);

        // negative values sum without saturation
        step(1'b1, 16'hFFFF, 1'b0, 1'b0, 8'd3);
        step(1'b1, 16'hFFFE, 1'b0, 1'b0, 8'd3);
        step(1'b1, 16'h0001, 1'b0, 1'b0, 8'd3);
        expect_out(16'hFFFE, 1'b0, 8'd0);
        idle(3);

        // reset mid-frame discards the partial frame
        step(1'b1, 16'h1234, 1'b1, 1'b0, 8'd4);
        step(1'b1, 16'h1234, 1'b0, 1'b0, 8'd4);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 8'd4);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_acc_out", {16'b0, acc_out}, 32'd0);
        chk("rst2_out_sat", {31'b0, out_sat}, 32'd0);
        chk("rst2_ovf_cnt", {24'b0, ovf_cnt}, 32'd0);
        chk("rst2_out_valid", {31'b0, out_valid}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0001, 1'b0, 1'b0, 8'd4);
        expect_out(16'h0004, 1'b0, 8'd0);
        idle(3);

        // averaging frame: sum 0x0403, rounded shift by 2 gives 0x0101
        step(1'b1, 16'h0100, 1'b0, 1'b0, 8'd4);
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0101, 1'b0, 1'b0, 8'd4);
`ifdef FXP_ACC_AVG_EN
        expect_out(16'h0101, 1'b0, 8'd0);
`else
        expect_out(16'h0403, 1'b0, 8'd0);
`endif
        idle(4);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
